// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: default geometry and
// the NOP encoding that the fetch register holds after reset.
package if_pkg;

    // Default instruction word width in bits.
    localparam int INSTR_W_DEFAULT = 32;

    // Default number of instruction memory words (power of two, at least 2).
    localparam int DEPTH_DEFAULT = 32;

    // Encoding of the no-operation word held in the fetch register after reset.
    localparam logic [31:0] NOP = 32'h0;

    // Returns 1 when depth is a legal memory size for the fetch stage.
    function automatic bit depth_is_legal(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bus between the fetch stage and its surroundings: instruction memory
// write port, redirect request, ID-stage handshake and fetch outputs.
// Optional feature macro: IF_STAGE_PERF_CNT_EN adds fetch_count.
interface if_stage_if
    import if_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEFAULT,
    parameter int DEPTH   = DEPTH_DEFAULT
);
    localparam int PC_W = $clog2(DEPTH);

    // Instruction memory write port
    logic               imem_we;
    logic [PC_W-1:0]    imem_waddr;
    logic [INSTR_W-1:0] imem_wdata;

    // Redirect from a later stage
    logic               br_taken;
    logic [PC_W-1:0]    br_target;

    // ID-stage handshake and fetched word
    logic               id_ready;
    logic               if_id_valid;
    logic [INSTR_W-1:0] if_id_instr;
    logic [PC_W-1:0]    if_id_pc;

    // Next fetch address
    logic [PC_W-1:0]    pc;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0]        fetch_count;
`endif

    // Side that drives the stage inputs and observes its outputs.
    modport master (
        output imem_we,
        output imem_waddr,
        output imem_wdata,
        output br_taken,
        output br_target,
        output id_ready,
        input  if_id_valid,
        input  if_id_instr,
        input  if_id_pc,
`ifdef IF_STAGE_PERF_CNT_EN
        input  fetch_count,
`endif
        input  pc
    );

    // The fetch stage itself.
    modport slave (
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata,
        input  br_taken,
        input  br_target,
        input  id_ready,
        output if_id_valid,
        output if_id_instr,
        output if_id_pc,
`ifdef IF_STAGE_PERF_CNT_EN
        output fetch_count,
`endif
        output pc
    );

endinterface

// File: rtl/if_imem.sv
// Instruction memory: register array with one synchronous write port and one
// synchronous read port. The read-data register doubles as the IF/ID
// instruction register, which gives single-cycle fetch latency; it loads
// only when the stage advances so it holds across stalls and flushes.
// The array itself is never reset; only the read register is cleared to NOP.
module if_imem
    import if_pkg::*;
#(
    parameter  int INSTR_W = INSTR_W_DEFAULT,
    parameter  int DEPTH   = DEPTH_DEFAULT,
    localparam int PC_W    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic [PC_W-1:0]    i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic               i_re,
    input  logic [PC_W-1:0]    i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [INSTR_W-1:0] r_rdata;

    // Write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port; a same-cycle write to the read address yields the old word
    // because both sample the array before the edge updates it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= INSTR_W'(NOP);
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, redirect/flush and stall control,
// and the IF/ID output registers, fronting the if_imem instruction memory.
// Optional feature macro: IF_STAGE_PERF_CNT_EN adds a 32-bit handshake
// counter on bus.fetch_count.
module if_stage
    import if_pkg::*;
#(
    parameter  int INSTR_W = INSTR_W_DEFAULT,
    parameter  int DEPTH   = DEPTH_DEFAULT,
    localparam int PC_W    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.slave  bus
);

    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_if_id_pc;
    logic               r_if_id_valid;
    logic [INSTR_W-1:0] w_if_id_instr;
    logic               w_advance;
    logic               w_handshake;

    // A redirect always wins; otherwise move whenever the output slot is
    // empty or being consumed this cycle.
    assign w_advance   = !bus.br_taken && (!r_if_id_valid || bus.id_ready);
    assign w_handshake = r_if_id_valid && bus.id_ready;

    if_imem #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_imem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (bus.imem_we),
        .i_waddr (bus.imem_waddr),
        .i_wdata (bus.imem_wdata),
        .i_re    (w_advance),
        .i_raddr (r_pc),
        .o_rdata (w_if_id_instr)
    );

    // PC and IF/ID control: reset, then redirect/flush, then advance; a stall
    // falls through and holds every register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= '0;
            r_if_id_valid <= 1'b0;
            r_if_id_pc    <= '0;
        end else if (bus.br_taken) begin
            r_pc          <= bus.br_target;
            r_if_id_valid <= 1'b0;
        end else if (w_advance) begin
            r_pc          <= r_pc + PC_W'(1);
            r_if_id_valid <= 1'b1;
            r_if_id_pc    <= r_pc;
        end
    end

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] r_fetch_count;

    // Count handshakes; the 32-bit add wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= '0;
        end else if (w_handshake) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign bus.fetch_count = r_fetch_count;
`else
    logic w_unused_handshake;
    assign w_unused_handshake = w_handshake;
`endif

    assign bus.pc          = r_pc;
    assign bus.if_id_valid = r_if_id_valid;
    assign bus.if_id_pc    = r_if_id_pc;
    assign bus.if_id_instr = w_if_id_instr;

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage with an 8-word memory.
// Optional feature macro: IF_STAGE_PERF_CNT_EN enables the fetch_count checks.
module tb_if_stage;

    localparam int INSTR_W = 32;
    localparam int DEPTH   = 8;
    localparam int PC_W    = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    if_stage_if #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus();

    if_stage #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            br;
        logic [PC_W-1:0] tgt;
        logic            rdy;
        logic            e_valid;
        logic [PC_W-1:0] e_ifpc;
        logic [31:0]     e_instr;
        logic [PC_W-1:0] e_pc;
    } vec_t;

    vec_t        tv[$];
    logic [31:0] img [DEPTH];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [PC_W-1:0] eifpc,
                              input logic [31:0] einstr, input logic [PC_W-1:0] epc);
        check({tag, "_valid"}, 32'(bus.if_id_valid), 32'(ev));
        check({tag, "_ifpc"},  32'(bus.if_id_pc),    32'(eifpc));
        check({tag, "_instr"}, bus.if_id_instr,      einstr);
        check({tag, "_pc"},    32'(bus.pc),          32'(epc));
    endtask

    task automatic add(input logic br, input int tgt, input logic rdy, input logic ev,
                       input int eifpc, input logic [31:0] einstr, input int epc);
        tv.push_back('{br, PC_W'(tgt), rdy, ev, PC_W'(eifpc), einstr, PC_W'(epc)});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        img[0] = 32'h00884010; img[1] = 32'h00CC8810; img[2] = 32'h00A9A010;
        img[3] = 32'h0298C010; img[4] = 32'h00AA9010; img[5] = 32'h11111111;
        img[6] = 32'h22222222; img[7] = 32'h77777777;

        rst = 1'b1;
        bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0;
        bus.br_taken = 1'b0; bus.br_target = '0; bus.id_ready = 1'b0;
        tick();
        tick();

        // Memory preload happens while reset is held.
        for (int i = 0; i < DEPTH; i++) begin
            bus.imem_we = 1'b1; bus.imem_waddr = PC_W'(i); bus.imem_wdata = img[i];
            tick();
        end
        bus.imem_we = 1'b0;
        check_outs("reset", 1'b0, 0, 32'h0, 0);
`ifdef IF_STAGE_PERF_CNT_EN
        check("reset_cnt", bus.fetch_count, 32'd0);
`endif

        // Streaming, stall, flush, wrap and redirect sequences.
        add(0,0,1, 1,0,img[0],1);
        add(0,0,1, 1,1,img[1],2);
        add(0,0,1, 1,2,img[2],3);
        add(0,0,0, 1,2,img[2],3);
        add(0,0,0, 1,2,img[2],3);
        add(0,0,0, 1,2,img[2],3);
        add(0,0,1, 1,3,img[3],4);
        add(0,0,0, 1,3,img[3],4);
        add(1,1,0, 0,3,img[3],1);
        add(0,0,1, 1,1,img[1],2);
        add(0,0,1, 1,2,img[2],3);
        add(0,0,1, 1,3,img[3],4);
        add(0,0,1, 1,4,img[4],5);
        add(0,0,1, 1,5,img[5],6);
        add(0,0,1, 1,6,img[6],7);
        add(0,0,1, 1,7,img[7],0);
        add(0,0,1, 1,0,img[0],1);
        add(1,7,1, 0,0,img[0],7);
        add(0,0,1, 1,7,img[7],0);
        add(0,0,1, 1,0,img[0],1);
        add(1,5,1, 0,0,img[0],5);
        add(1,2,0, 0,0,img[0],2);
        add(0,0,0, 1,2,img[2],3);

        rst = 1'b0;
        for (int i = 0; i < tv.size(); i++) begin
            bus.br_taken  = tv[i].br;
            bus.br_target = tv[i].tgt;
            bus.id_ready  = tv[i].rdy;
            tick();
            check_outs($sformatf("v%0d", i), tv[i].e_valid, tv[i].e_ifpc, tv[i].e_instr, tv[i].e_pc);
        end

        // Write to address 3 in the same cycle it is fetched: old word returned.
        bus.br_taken = 1'b0; bus.id_ready = 1'b1;
        bus.imem_we = 1'b1; bus.imem_waddr = 3'd3; bus.imem_wdata = 32'hDEADBEEF;
        tick();
        bus.imem_we = 1'b0;
        check_outs("rbw_old", 1'b1, 3, img[3], 4);
        bus.br_taken = 1'b1; bus.br_target = 3'd3;
        tick();
        check_outs("rbw_flush", 1'b0, 3, img[3], 3);
        bus.br_taken = 1'b0;
        tick();
        check_outs("rbw_new", 1'b1, 3, 32'hDEADBEEF, 4);

        // Restart from a clean reset, then count five handshakes.
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.id_ready = 1'b1;
        tick();
        check_outs("restart0", 1'b1, 0, img[0], 1);
        for (int i = 0; i < 5; i++) tick();
        check_outs("run5", 1'b1, 5, img[5], 6);
`ifdef IF_STAGE_PERF_CNT_EN
        check("cnt5", bus.fetch_count, 32'd5);
`endif

        // Reset overrides a simultaneous redirect and ready.
        rst = 1'b1; bus.br_taken = 1'b1; bus.br_target = 3'd5;
        tick();
        check_outs("rst_mid", 1'b0, 0, 32'h0, 0);
`ifdef IF_STAGE_PERF_CNT_EN
        check("rst_cnt", bus.fetch_count, 32'd0);
`endif
        rst = 1'b0; bus.br_taken = 1'b0;
        tick();
        check_outs("post_rst", 1'b1, 0, img[0], 1);
        tick();
        check_outs("post_rst_mem3", 1'b1, 1, img[1], 2);
        tick();
        tick();
        check_outs("mem3_kept", 1'b1, 3, 32'hDEADBEEF, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter INSTR_W, 32, SHALL set the instruction word width.
REQ-003 Parameter DEPTH, 32, SHALL set the instruction memory words; it SHALL be a power of two and at least 2.
REQ-004 Local parameter PC_W, $clog2(DEPTH), SHALL set the word-address PC width.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 imem_we  in  1  instruction memory write enable.
REQ-008 imem_waddr  in  PC_W  write word address.
REQ-009 imem_wdata  in  INSTR_W  write data.
REQ-010 br_taken  in  1  redirect request from a later stage.
REQ-011 br_target  in  PC_W  redirect word address.
REQ-012 id_ready  in  1  ID stage can accept the current word.
REQ-013 if_id_valid  out  1  if_id_instr and if_id_pc hold a valid fetch.
REQ-014 if_id_instr  out  INSTR_W  fetched instruction, registered.
REQ-015 if_id_pc  out  PC_W  word address of if_id_instr, registered.
REQ-016 pc  out  PC_W  next fetch address, registered.

Function
REQ-017 The instruction memory SHALL be written at the clk edge when imem_we=1; it SHALL NOT be reset.
REQ-018 A fetch of memory at an address being written in the same cycle SHALL return the pre-write data.
REQ-019 A handshake SHALL occur in a cycle when if_id_valid=1 and id_ready=1.
REQ-020 The stage SHALL advance when br_taken=0 and (if_id_valid=0 or id_ready=1).
REQ-021 On advance: if_id_instr<=mem[pc], if_id_pc<=pc, if_id_valid<=1, and pc<=(pc+1) mod DEPTH.
REQ-022 When br_taken=1: pc<=br_target and if_id_valid<=0 (flush); if_id_instr and if_id_pc SHALL hold.
REQ-023 br_taken SHALL take priority over a stall and over an advance in the same cycle.
REQ-024 When stalled (if_id_valid=1, id_ready=0, br_taken=0), all outputs SHALL hold their values.
REQ-025 Fetch latency SHALL be one cycle: the word at pc appears on if_id_instr at the next edge.
REQ-026 From pc=DEPTH-1, an advance SHALL wrap pc to 0.
REQ-027 Throughput SHALL be one instruction per cycle while id_ready=1 and br_taken=0.

Reset
REQ-028 While rst=1 at an edge: pc<=0, if_id_valid<=0, if_id_instr<=0, if_id_pc<=0; memory contents SHALL be retained.
REQ-029 rst SHALL override br_taken and id_ready.
REQ-030 The first edge with rst=0 SHALL fetch address 0.

Configuration
REQ-031 With macro IF_STAGE_PERF_CNT_EN defined, the block SHALL add output fetch_count [31:0].
REQ-032 fetch_count SHALL reset to 0, increment by 1 per handshake, and wrap from 2^32-1 to 0.
REQ-033 Without IF_STAGE_PERF_CNT_EN, the port and the counter logic SHALL be absent.

Structure
REQ-034 Package if_pkg SHALL hold the default INSTR_W and DEPTH and the NOP encoding constant (32'h0).
REQ-035 The memory SHALL be the sub-module if_imem: a register array with one synchronous write port and one synchronous read port.
REQ-036 The PC, the flush and stall control, and the output registers SHALL stay in if_stage.

Verification
REQ-037 Preload mem[0..4] = 0x00884010, 0x00CC8810, 0x00A9A010, 0x0298C010, 0x00AA9010; release rst; hold id_ready=1 -> if_id_instr shows these words on consecutive edges, with if_id_pc 0..4 and if_id_valid=1.
REQ-038 Hold id_ready=0 for 3 cycles after if_id_pc=2 -> outputs and pc hold; on release, the next edge gives if_id_pc=3.
REQ-039 Assert br_taken=1 with br_target=1 while stalled -> next edge gives if_id_valid=0 and pc=1; the following edge gives if_id_pc=1 and if_id_instr=0x00CC8810.
REQ-040 DEPTH=8; run from pc=7 -> if_id_pc=7, then 0.
REQ-041 Write mem[3]=0xDEADBEEF in the same cycle as a fetch of address 3 -> old word is returned; the next fetch of 3 returns 0xDEADBEEF.
REQ-042 Apply rst mid-stream with IF_STAGE_PERF_CNT_EN defined, after 5 handshakes -> fetch_count=5 before reset; after the reset edge pc=0, if_id_valid=0 and fetch_count=0.
